// File: rtl/doom_patch_dma.sv
// Command-driven blitter: palette load, palette-mapped patch copy and solid fill from
// shared memory into the VGA pixel buffer, programmed through a small Avalon-MM slave.
module doom_patch_dma #(
    parameter int ADDR_W    = 32,
    parameter int MEM_DW    = 8,
    parameter int PIX_W     = 16,
    parameter int PAL_DEPTH = 256,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        hps_address,
    input  logic              hps_read,
    input  logic              hps_write,
    input  logic [31:0]       hps_writedata,
    output logic [31:0]       hps_readdata,
    output logic              hps_waitrequest,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [MEM_DW-1:0] mem_readdata,
    input  logic              mem_waitrequest,
    output logic [ADDR_W-1:0] vga_address,
    output logic              vga_write,
    output logic [PIX_W-1:0]  vga_writedata,
    input  logic              vga_waitrequest
);
    localparam int PB     = PIX_W / 8;
    localparam int IDX_W  = $clog2(PAL_DEPTH);
    localparam int CTRL_W = IDX_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_LUT, S_WR, S_PAL} state_t;
    typedef enum logic [1:0] {M_PAL, M_PATCH, M_FILL} mode_t;

    state_t            state;
    mode_t             mode;
    logic [ADDR_W-1:0] src_reg, dst_reg, src_w, dst_w;
    logic [CNT_W-1:0]  count_reg, cnt_w;
    logic [PIX_W-1:0]  fill_reg, pal_acc;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [IDX_W-1:0]  idx_reg, pal_ptr;
    logic [7:0]        byte_cnt;
    logic              done, error, abort_pend;
    logic [PIX_W-1:0]  palette [PAL_DEPTH];

    logic busy, wr_acc, abort_req, last, skip;

    assign busy            = (state != S_IDLE);
    assign hps_waitrequest = busy && (hps_read || hps_write) && (hps_address <= 8'd5);
    assign wr_acc          = hps_write && !hps_waitrequest;
    // An abort written in the same cycle a transfer completes still stops the engine.
    assign abort_req       = abort_pend || (wr_acc && hps_address == 8'd7);
    assign last            = (cnt_w == CNT_W'(1));
    assign skip            = ctrl_reg[0] && (idx_reg == ctrl_reg[CTRL_W-1:1]);

    always_comb begin
        hps_readdata = '0;
        if (hps_read && !hps_waitrequest) begin
            case (hps_address)
                8'd1:    hps_readdata = 32'(src_reg);
                8'd2:    hps_readdata = 32'(dst_reg);
                8'd3:    hps_readdata = 32'(count_reg);
                8'd4:    hps_readdata = 32'(fill_reg);
                8'd5:    hps_readdata = 32'(ctrl_reg);
                8'd6:    hps_readdata = {16'(cnt_w), 13'd0, error, done, busy};
                default: hps_readdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_PAL) palette[pal_ptr] <= pal_acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            mode          <= M_PAL;
            src_reg       <= '0;
            dst_reg       <= '0;
            count_reg     <= '0;
            fill_reg      <= '0;
            ctrl_reg      <= '0;
            src_w         <= '0;
            dst_w         <= '0;
            cnt_w         <= '0;
            pal_acc       <= '0;
            idx_reg       <= '0;
            pal_ptr       <= '0;
            byte_cnt      <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            abort_pend    <= 1'b0;
            mem_address   <= '0;
            mem_read      <= 1'b0;
            vga_address   <= '0;
            vga_write     <= 1'b0;
            vga_writedata <= '0;
        end else begin
            if (wr_acc) begin
                case (hps_address)
                    8'd1:    src_reg   <= ADDR_W'(hps_writedata);
                    8'd2:    dst_reg   <= ADDR_W'(hps_writedata);
                    8'd3:    count_reg <= CNT_W'(hps_writedata);
                    8'd4:    fill_reg  <= PIX_W'(hps_writedata);
                    8'd5:    ctrl_reg  <= CTRL_W'(hps_writedata);
                    8'd7:    if (busy) abort_pend <= 1'b1;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (wr_acc && hps_address == 8'd0) begin
                        done       <= 1'b0;
                        error      <= 1'b0;
                        abort_pend <= 1'b0;
                        src_w      <= src_reg;
                        dst_w      <= dst_reg;
                        cnt_w      <= count_reg;
                        byte_cnt   <= '0;
                        pal_ptr    <= '0;
                        if (hps_writedata < 32'd1 || hps_writedata > 32'd3) begin
                            error <= 1'b1;
                        end else if (count_reg == '0) begin
                            done <= 1'b1;
                        end else if (hps_writedata == 32'd3) begin
                            mode          <= M_FILL;
                            state         <= S_WR;
                            vga_write     <= 1'b1;
                            vga_address   <= dst_reg;
                            vga_writedata <= fill_reg;
                        end else begin
                            mode        <= (hps_writedata == 32'd1) ? M_PAL : M_PATCH;
                            state       <= S_RD;
                            mem_read    <= 1'b1;
                            mem_address <= src_reg;
                        end
                    end
                end

                S_RD: begin
                    if (!mem_waitrequest) begin
                        src_w    <= src_w + ADDR_W'(1);
                        mem_read <= 1'b0;
                        if (abort_req) begin
                            state      <= S_IDLE;
                            error      <= 1'b1;
                            abort_pend <= 1'b0;
                        end else if (mode == M_PATCH) begin
                            idx_reg <= IDX_W'(mem_readdata);
                            state   <= S_LUT;
                        end else begin
                            // Little-endian assembly: each new byte enters at the top.
                            pal_acc <= (pal_acc >> MEM_DW) | (PIX_W'(mem_readdata) << (PIX_W - MEM_DW));
                            if (byte_cnt == 8'(PB - 1)) begin
                                byte_cnt <= '0;
                                state    <= S_PAL;
                            end else begin
                                byte_cnt    <= byte_cnt + 8'd1;
                                mem_read    <= 1'b1;
                                mem_address <= src_w + ADDR_W'(1);
                            end
                        end
                    end
                end

                S_LUT: begin
                    if (abort_req) begin
                        state      <= S_IDLE;
                        error      <= 1'b1;
                        abort_pend <= 1'b0;
                    end else if (skip) begin
                        dst_w <= dst_w + ADDR_W'(PB);
                        cnt_w <= cnt_w - CNT_W'(1);
                        if (last) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end else begin
                            state       <= S_RD;
                            mem_read    <= 1'b1;
                            mem_address <= src_w;
                        end
                    end else begin
                        state         <= S_WR;
                        vga_write     <= 1'b1;
                        vga_address   <= dst_w;
                        vga_writedata <= palette[idx_reg];
                    end
                end

                S_WR: begin
                    if (!vga_waitrequest) begin
                        dst_w <= dst_w + ADDR_W'(PB);
                        cnt_w <= cnt_w - CNT_W'(1);
                        if (abort_req) begin
                            state      <= S_IDLE;
                            error      <= 1'b1;
                            abort_pend <= 1'b0;
                            vga_write  <= 1'b0;
                        end else if (last) begin
                            state     <= S_IDLE;
                            done      <= 1'b1;
                            vga_write <= 1'b0;
                        end else if (mode == M_FILL) begin
                            vga_address <= dst_w + ADDR_W'(PB);
                        end else begin
                            vga_write   <= 1'b0;
                            state       <= S_RD;
                            mem_read    <= 1'b1;
                            mem_address <= src_w;
                        end
                    end
                end

                S_PAL: begin
                    cnt_w   <= cnt_w - CNT_W'(1);
                    pal_ptr <= pal_ptr + IDX_W'(1);
                    if (abort_req) begin
                        state      <= S_IDLE;
                        error      <= 1'b1;
                        abort_pend <= 1'b0;
                    end else if (last) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        state       <= S_RD;
                        mem_read    <= 1'b1;
                        mem_address <= src_w;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_doom_patch_dma.sv
// Scoreboard bench for doom_patch_dma: memory/VGA slave models with stall injection.
module tb_doom_patch_dma;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  hps_address = '0;
    logic        hps_read = 1'b0, hps_write = 1'b0;
    logic [31:0] hps_writedata = '0;
    logic [31:0] hps_readdata;
    logic        hps_waitrequest;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [7:0]  mem_readdata;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] vga_address;
    logic        vga_write;
    logic [15:0] vga_writedata;
    logic        vga_waitrequest = 1'b0;

    doom_patch_dma #(.ADDR_W(32), .MEM_DW(8), .PIX_W(16), .PAL_DEPTH(256), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .hps_address(hps_address), .hps_read(hps_read), .hps_write(hps_write),
        .hps_writedata(hps_writedata), .hps_readdata(hps_readdata), .hps_waitrequest(hps_waitrequest),
        .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest),
        .vga_address(vga_address), .vga_write(vga_write), .vga_writedata(vga_writedata),
        .vga_waitrequest(vga_waitrequest)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] mem [256];
    assign mem_readdata = mem[mem_address[7:0]];

    logic [31:0] mem_exp_q[$];
    logic [47:0] vga_exp_q[$];
    logic [31:0] mexp;
    logic [47:0] vexp;

    int rd_count = 0, wr_count = 0;
    int mem_stall_idx = -1, mem_stall_len = 0, vga_stall_idx = -1, vga_stall_len = 0;
    int mem_hold_cnt = 0, vga_hold_cnt = 0;
    int mem_stall_seen = 0, vga_stall_seen = 0;

    // Stall driver: holds waitrequest for a chosen transaction index
    always @(posedge clk) begin
        #2;
        if (mem_read && rd_count == mem_stall_idx && mem_hold_cnt < mem_stall_len) begin
            mem_waitrequest = 1'b1;
            mem_hold_cnt++;
        end else begin
            mem_waitrequest = 1'b0;
            if (rd_count != mem_stall_idx) mem_hold_cnt = 0;
        end
        if (vga_write && wr_count == vga_stall_idx && vga_hold_cnt < vga_stall_len) begin
            vga_waitrequest = 1'b1;
            vga_hold_cnt++;
        end else begin
            vga_waitrequest = 1'b0;
            if (wr_count != vga_stall_idx) vga_hold_cnt = 0;
        end
    end

    logic        mem_held = 1'b0, vga_held = 1'b0;
    logic [31:0] mhold_addr, vhold_addr;
    logic [15:0] vhold_data;

    // Monitors: acceptance and stall stability, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            mem_held = 1'b0;
            vga_held = 1'b0;
        end else begin
            if (mem_held) begin
                check_eq("mem_hold_read", mem_read, 1'b1);
                check_eq("mem_hold_addr", mem_address, mhold_addr);
            end
            mem_held = mem_read && mem_waitrequest;
            if (mem_held) begin
                mhold_addr = mem_address;
                mem_stall_seen++;
            end
            if (mem_read && !mem_waitrequest) begin
                rd_count++;
                check_eq("mem_rd_expected", mem_exp_q.size() != 0, 1'b1);
                if (mem_exp_q.size() != 0) begin
                    mexp = mem_exp_q.pop_front();
                    check_eq("mem_rd_addr", mem_address, mexp);
                end
            end

            if (vga_held) begin
                check_eq("vga_hold_write", vga_write, 1'b1);
                check_eq("vga_hold_addr", vga_address, vhold_addr);
                check_eq("vga_hold_data", vga_writedata, vhold_data);
            end
            vga_held = vga_write && vga_waitrequest;
            if (vga_held) begin
                vhold_addr = vga_address;
                vhold_data = vga_writedata;
                vga_stall_seen++;
            end
            if (vga_write && !vga_waitrequest) begin
                wr_count++;
                check_eq("vga_wr_expected", vga_exp_q.size() != 0, 1'b1);
                if (vga_exp_q.size() != 0) begin
                    vexp = vga_exp_q.pop_front();
                    check_eq("vga_wr_addr", vga_address, vexp[47:16]);
                    check_eq("vga_wr_data", vga_writedata, vexp[15:0]);
                end
            end
        end
    end

    task automatic hps_rd(input logic [7:0] a, output logic [31:0] d, output int stalls);
        @(posedge clk); #1;
        hps_write = 1'b0; hps_read = 1'b1; hps_address = a;
        stalls = 0;
        @(negedge clk);
        while (hps_waitrequest && stalls < 500) begin
            stalls++;
            @(negedge clk);
        end
        d = hps_readdata;
    endtask

    task automatic hps_wr(input logic [7:0] a, input logic [31:0] v, output int stalls);
        @(posedge clk); #1;
        hps_read = 1'b0; hps_write = 1'b1; hps_address = a; hps_writedata = v;
        stalls = 0;
        @(negedge clk);
        while (hps_waitrequest && stalls < 500) begin
            stalls++;
            @(negedge clk);
        end
    endtask

    task automatic hps_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            hps_read = 1'b0; hps_write = 1'b0;
        end
    endtask

    task automatic poll_status(output logic [31:0] d, output int busy_cyc, output int stall_sum);
        int s;
        int tries;
        busy_cyc = 0; stall_sum = 0; tries = 0;
        d = '0;
        do begin
            hps_rd(8'd6, d, s);
            stall_sum += s;
            if (d[0]) busy_cyc++;
            tries++;
        end while (d[0] && tries < 300);
        check_eq("poll_timeout", tries >= 300, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    logic [31:0] d;
    int s, bc, ss, base_rd, base_wr, base_st;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 8'h34; mem[8'h11] = 8'h12; mem[8'h12] = 8'h78; mem[8'h13] = 8'h56;
        mem[8'h20] = 8'h00; mem[8'h21] = 8'h01; mem[8'h22] = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_read", mem_read, 1'b0);
        check_eq("rst_vga_write", vga_write, 1'b0);
        check_eq("rst_mem_addr", mem_address, 32'h0);
        check_eq("rst_vga_addr", vga_address, 32'h0);
        check_eq("rst_vga_data", vga_writedata, 16'h0);
        check_eq("rst_readdata", hps_readdata, 32'h0);
        check_eq("rst_waitreq", hps_waitrequest, 1'b0);
        @(posedge clk); #1 reset = 1'b0;

        // Register access
        hps_wr(8'd1, 32'h3000_0000, s); check_eq("reg_src_wr_stall", s, 0);
        hps_wr(8'd3, 32'd4, s);         check_eq("reg_cnt_wr_stall", s, 0);
        hps_rd(8'd1, d, s); check_eq("reg_src_rb", d, 32'h3000_0000); check_eq("reg_src_rd_stall", s, 0);
        hps_rd(8'd3, d, s); check_eq("reg_cnt_rb", d, 32'd4);
        hps_rd(8'd6, d, s); check_eq("reg_status0", d, 32'h0);
        hps_rd(8'd9, d, s); check_eq("reg_unmapped", d, 32'h0);

        // PAL_LOAD of two entries
        base_wr = wr_count;
        hps_wr(8'd1, 32'h10, s);
        hps_wr(8'd3, 32'd2, s);
        for (int i = 0; i < 4; i++) mem_exp_q.push_back(32'h10 + i);
        hps_wr(8'd0, 32'd1, s);
        poll_status(d, bc, ss);
        check_eq("pal_busy_cycles", bc, 6);
        check_eq("pal_status", d[2:0], 3'b010);
        check_eq("pal_remaining", d[31:16], 16'd0);
        check_eq("pal_status_stall", ss, 0);
        check_eq("pal_reads_left", mem_exp_q.size(), 0);
        check_eq("pal_vga_writes", wr_count - base_wr, 0);

        // PATCH with a 2-cycle read stall on the second index
        hps_wr(8'd1, 32'h20, s);
        hps_wr(8'd2, 32'h100, s);
        hps_wr(8'd3, 32'd3, s);
        hps_wr(8'd5, 32'h0, s);
        base_st = mem_stall_seen;
        mem_stall_len = 2; mem_stall_idx = rd_count + 1;
        for (int i = 0; i < 3; i++) mem_exp_q.push_back(32'h20 + i);
        vga_exp_q.push_back({32'h100, 16'h1234});
        vga_exp_q.push_back({32'h102, 16'h5678});
        vga_exp_q.push_back({32'h104, 16'h1234});
        hps_wr(8'd0, 32'd2, s);
        poll_status(d, bc, ss);
        check_eq("patch_busy_cycles", bc, 11);
        check_eq("patch_status", d[2:0], 3'b010);
        check_eq("patch_remaining", d[31:16], 16'd0);
        check_eq("patch_vga_left", vga_exp_q.size(), 0);
        check_eq("patch_rd_left", mem_exp_q.size(), 0);
        check_eq("patch_stall_cycles", mem_stall_seen - base_st, 2);
        mem_stall_idx = -1;

        // Transparent index 0
        hps_wr(8'd5, 32'h1, s);
        for (int i = 0; i < 3; i++) mem_exp_q.push_back(32'h20 + i);
        vga_exp_q.push_back({32'h102, 16'h5678});
        base_wr = wr_count;
        hps_wr(8'd0, 32'd2, s);
        poll_status(d, bc, ss);
        check_eq("trans_status", d[2:0], 3'b010);
        check_eq("trans_remaining", d[31:16], 16'd0);
        check_eq("trans_writes", wr_count - base_wr, 1);
        check_eq("trans_vga_left", vga_exp_q.size(), 0);

        // FILL with a 3-cycle write stall, plus stalled register write while busy
        hps_wr(8'd5, 32'h0, s);
        hps_wr(8'd4, 32'hF800, s);
        hps_wr(8'd2, 32'h100, s);
        hps_wr(8'd3, 32'd5, s);
        base_st = vga_stall_seen;
        vga_stall_len = 3; vga_stall_idx = wr_count + 1;
        for (int i = 0; i < 5; i++) vga_exp_q.push_back({32'h100 + 32'(2 * i), 16'hF800});
        hps_wr(8'd0, 32'd3, s);
        hps_rd(8'd6, d, s);
        check_eq("fill_status_stall", s, 0);
        check_eq("fill_busy", d[0], 1'b1);
        hps_wr(8'd1, 32'h40, s);
        check_eq("fill_src_wr_stall", s, 7);
        hps_rd(8'd1, d, s);  check_eq("fill_src_rb", d, 32'h40);
        hps_rd(8'd6, d, s);  check_eq("fill_status", d[2:0], 3'b010);
        check_eq("fill_vga_left", vga_exp_q.size(), 0);
        check_eq("fill_stall_cycles", vga_stall_seen - base_st, 3);
        vga_stall_idx = -1;

        // Abort during a long FILL
        hps_wr(8'd2, 32'h200, s);
        hps_wr(8'd3, 32'd100, s);
        for (int i = 0; i < 100; i++) vga_exp_q.push_back({32'h200 + 32'(2 * i), 16'hF800});
        hps_wr(8'd0, 32'd3, s);
        hps_idle(4);
        hps_wr(8'd7, 32'h0, s);
        check_eq("abort_stall", s, 0);
        hps_idle(5);
        check_eq("abort_writes", 100 - vga_exp_q.size(), 5);
        hps_rd(8'd6, d, s);
        check_eq("abort_status", d[2:0], 3'b100);
        check_eq("abort_remaining", d[31:16], 16'd95);
        vga_exp_q.delete();

        // COUNT = 0 and an illegal command code
        base_rd = rd_count; base_wr = wr_count;
        hps_wr(8'd3, 32'd0, s);
        hps_wr(8'd0, 32'd2, s);
        hps_rd(8'd6, d, s);
        check_eq("cnt0_status", d[2:0], 3'b010);
        hps_wr(8'd3, 32'd3, s);
        hps_wr(8'd0, 32'd9, s);
        hps_idle(3);
        hps_rd(8'd6, d, s);
        check_eq("badcmd_status", d[2:0], 3'b100);
        check_eq("badcmd_reads", rd_count - base_rd, 0);
        check_eq("badcmd_writes", wr_count - base_wr, 0);

        // Reset mid-PATCH while a read is stalled
        hps_wr(8'd1, 32'h20, s);
        mem_stall_len = 1000; mem_stall_idx = rd_count;
        mem_exp_q.push_back(32'h20);
        hps_wr(8'd0, 32'd2, s);
        hps_idle(3);
        check_eq("prerst_mem_read", mem_read, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_mem_read", mem_read, 1'b0);
        check_eq("midrst_vga_write", vga_write, 1'b0);
        check_eq("midrst_mem_addr", mem_address, 32'h0);
        mem_stall_idx = -1;
        mem_exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        hps_rd(8'd6, d, s);
        check_eq("postrst_status", d, 32'h0);
        hps_idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/doom_patch_dma.md
# doom_patch_dma

Parametrised command-driven blitter between the HPS and the DOOM frame buffer. The HPS programs source, destination, count and mode through a small Avalon-MM slave, then writes a command word. The block streams bytes from shared memory over an Avalon-MM read master, optionally maps them through an on-chip palette (with transparent-index skipping), and writes pixels to the VGA pixel buffer over an Avalon-MM write master. It succeeds the fixed-width patch/palette engine with parametrised widths, palette depth, a fill mode and abort support.

## Interface
- ADDR_W, 32: width of mem/vga byte addresses
- MEM_DW, 8: shared-memory data width (one byte per read)
- PIX_W, 16: pixel width; multiple of 8; PB = PIX_W/8 bytes per pixel
- PAL_DEPTH, 256: palette entries; IDX_W = clog2(PAL_DEPTH)
- CNT_W, 16: transfer count width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hps_address  in  8  word index of register
- hps_read / hps_write  in  1  slave strobes
- hps_writedata  in  32  register write data
- hps_readdata  out  32  register read data
- hps_waitrequest  out  1  slave stall
- mem_address  out  ADDR_W  source byte address
- mem_read  out  1  read strobe
- mem_readdata  in  MEM_DW  valid in the cycle mem_waitrequest is low with mem_read high
- mem_waitrequest  in  1  read stall
- vga_address  out  ADDR_W  destination byte address
- vga_write  out  1  write strobe
- vga_writedata  out  PIX_W  pixel
- vga_waitrequest  in  1  write stall

## Operation
- Registers (word index): 0 CMD (W), 1 SRC, 2 DST, 3 COUNT (low CNT_W bits), 4 FILL (low PIX_W bits), 5 CTRL (bit0 transparent enable, bits[IDX_W:1] transparent index), 6 STATUS (R), 7 ABORT (W, any data). Registers 1-5 read back their values. Unmapped reads return 0; unmapped writes are ignored.
- STATUS: bit0 busy, bit1 done (sticky), bit2 error (sticky), bits[31:16] remaining count.
- CMD codes:
  - 1 PAL_LOAD: load COUNT entries starting at palette[0]. Each entry is PB bytes read from SRC upward, little-endian.
  - 2 PATCH: read COUNT index bytes; low IDX_W bits address the palette; write the looked-up pixel.
  - 3 FILL: write FILL COUNT times with no memory reads.
  - Any other code sets error, no transfer.
- A CMD write clears done and error and latches working copies of SRC, DST and COUNT.
- States: IDLE → RD (hold mem_read until !mem_waitrequest; capture byte; src += 1) → LUT (one-cycle synchronous palette read; PATCH only) → WR (hold vga_write until !vga_waitrequest; dst += PB; count -= 1) → RD, or IDLE when count reaches 0.
- PAL_LOAD loops in RD until PB bytes are assembled, then writes the palette for one cycle with no VGA traffic; count -= 1.
- FILL: IDLE → WR loop.
- Transparent skip (PATCH, CTRL bit0 set, index == key): skip WR; dst still += PB; count -= 1.
- COUNT = 0: no bus traffic; done set on the cycle after the CMD write.
- Addresses wrap modulo 2^ADDR_W; count and index never wrap (the upper index bits are ignored).

## Timing
- Reset values: all strobes 0; addresses, writedata and hps_readdata 0; state IDLE; registers 0; palette contents undefined.
- hps_waitrequest is combinational:
  - high for a read or write to registers 0-5 while busy;
  - low for STATUS and ABORT at all times and for every access when idle.
- hps_readdata is valid in the cycle the read is accepted.
- Busy rises the cycle after the accepted CMD write. Done rises and busy falls together on the cycle after the last count decrement.
- mem_address/mem_read and vga_address/vga_writedata/vga_write are registered and held stable while the corresponding waitrequest is high.
- Throughput with zero waitrequest:
  - PATCH: 3 cycles/pixel.
  - PAL_LOAD: PB+1 cycles/entry.
  - FILL: 1 cycle/pixel (vga_write held high back-to-back).
- ABORT while busy: finish the bus transaction in progress, then IDLE with done=0, error=1. ABORT while idle has no effect.
- Reset mid-transfer: outputs drop immediately, asynchronously.

## Test plan
- Register access: write SRC=0x3000_0000, then COUNT=4; read back both → same values; STATUS=0; hps_waitrequest low throughout.
- PAL_LOAD: COUNT=2, memory bytes 34 12 78 56 → palette[0]=0x1234, palette[1]=0x5678; 0 VGA writes; done=1 after 6 cycles busy with zero wait.
- PATCH with stalls: DST=0x100, COUNT=3, indices 0,1,0, mem_waitrequest high 2 cycles on the second read → VGA writes 0x1234@0x100, 0x5678@0x102, 0x1234@0x104; address and strobe stable during stall.
- Transparent: CTRL = enable with key 0, same PATCH → single VGA write 0x5678@0x102; done=1, remaining=0.
- FILL and hps stall: FILL=0xF800, COUNT=5, vga_waitrequest high 3 cycles → 5 writes, dst ends 0x10A; a write to SRC during busy is stalled until busy falls; STATUS reads are never stalled.
- Abort, bad code and reset: ABORT during FILL of 100 → stops after the current write, error=1. CMD=9 → error=1, no traffic. Reset mid-PATCH → mem_read/vga_write drop immediately; STATUS=0.
